// File: rtl/fyra_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit, its skid buffer and the imem interface.
package fyra_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
// The fetch unit is the master, the memory is the slave.
interface fetch_unit_if import fyra_pkg::*; ();
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction
// while the IF/ID output register is stalled.
module fetch_skid import fyra_pkg::*; (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            load_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic            valid_o,
   output logic            valid_d_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o
);
   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         instr_d = instr_i;
      end else if (pop_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= INSTR_NOP;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o   = valid_q;
   assign valid_d_o = valid_d;
   assign pc_o      = pc_q;
   assign instr_o   = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request,
// IF/ID output register backed by a one-entry skid buffer.
module fetch_unit import fyra_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            branch_sel,
   input  logic            jump,
   input  logic [XLEN-1:0] branch_target,
   input  logic            stall,
   fetch_unit_if.master    imem,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            flush
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            kill_q, kill_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] out_instr_q, out_instr_d;

   logic            redirect, consume, resp_ok;
   logic            skid_valid, skid_valid_d;
   logic            skid_load, skid_pop;
   logic [XLEN-1:0] skid_pc, skid_instr;
   logic [XLEN-1:0] redirect_pc;
   logic            unused_tgt;

   assign unused_tgt  = ^branch_target[1:0];
   assign redirect    = branch_sel | jump;
   assign flush       = redirect;
   assign redirect_pc = {branch_target[XLEN-1:2], 2'b00};
   assign consume     = out_valid_q & ~stall;
   assign resp_ok     = (state_q == WAIT) & imem.imem_rvalid
                      & ~kill_q & ~redirect;
   assign skid_load   = resp_ok & out_valid_q & ~consume;
   assign skid_pop    = consume & skid_valid;

   fetch_skid u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (redirect),
      .load_i    (skid_load),
      .pop_i     (skid_pop),
      .pc_i      (req_pc_q),
      .instr_i   (imem.imem_rdata),
      .valid_o   (skid_valid),
      .valid_d_o (skid_valid_d),
      .pc_o      (skid_pc),
      .instr_o   (skid_instr)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      kill_d   = kill_q;
      unique case (state_q)
         IDLE: begin
            if (redirect) pc_d = redirect_pc;
            if (redirect || !skid_valid) state_d = REQ;
         end
         REQ: begin
            if (imem.imem_gnt) begin
               req_pc_d = pc_q;
               kill_d   = redirect;
               pc_d     = redirect ? redirect_pc : pc_q + 32'd4;
               state_d  = WAIT;
            end else if (redirect) begin
               pc_d = redirect_pc;
            end
         end
         WAIT: begin
            if (redirect) pc_d = redirect_pc;
            if (imem.imem_rvalid) begin
               kill_d  = 1'b0;
               state_d = (resp_ok && skid_valid_d) ? IDLE : REQ;
            end else if (redirect) begin
               kill_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Skid drains before any new response can land, keeping program order.
   always_comb begin
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      if (redirect) begin
         out_valid_d = 1'b0;
      end else if (skid_pop) begin
         out_valid_d = 1'b1;
         out_pc_d    = skid_pc;
         out_instr_d = skid_instr;
      end else if (resp_ok && (!out_valid_q || consume)) begin
         out_valid_d = 1'b1;
         out_pc_d    = req_pc_q;
         out_instr_d = imem.imem_rdata;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         kill_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= INSTR_NOP;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         kill_q      <= kill_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
      end
   end

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = pc_q;
   assign if_valid       = out_valid_q;
   assign if_pc          = out_pc_q;
   assign if_instr       = out_instr_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 branch_sel  input  1  conditional branch taken, from branch control in EX.
REQ-005 jump  input  1  unconditional redirect (JAL/JALR) from EX.
REQ-006 branch_target  input  32  redirect address; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 stall  input  1  hazard hold; IF/ID output SHALL not be consumed while high.
REQ-008 imem_req  output  1  fetch request valid.
REQ-009 imem_addr  output  32  fetch address, word-aligned.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  read data valid; at most one response per accepted request, in order.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 if_valid  output  1  if_pc/if_instr hold a live instruction.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_instr  output  32  fetched instruction.
REQ-016 flush  output  1  squash younger pipeline stages.

Function
REQ-017 redirect = branch_sel | jump; flush SHALL equal redirect combinationally, same cycle.
REQ-018 At most one request SHALL be outstanding (granted, response not yet returned).
REQ-019 FSM states IDLE, REQ, WAIT; imem_req SHALL be 1 only in REQ; imem_addr SHALL equal pc_q.
REQ-020 IDLE->REQ when the skid entry is empty (also the first edge after reset release).
REQ-021 REQ: on imem_gnt, pc_q <= pc_q+4 and ->WAIT; pc_q+4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-022 WAIT: on imem_rvalid, ->REQ if the skid entry is empty after this cycle's writes, else ->IDLE.
REQ-023 A response SHALL load the output register if it is empty or being consumed (if_valid & !stall), else the skid entry; its pc SHALL be the address the request was issued at.
REQ-024 When the output register is consumed and the skid entry is full, the skid SHALL move to output next cycle; no instruction SHALL be lost or duplicated.
REQ-025 Redirect in any state: pc_q <= {branch_target[31:2],2'b00}; output and skid SHALL be invalidated next cycle (if_valid=0).
REQ-026 Redirect in REQ with imem_gnt in the same cycle: the grant SHALL be honoured, the response marked kill, ->WAIT.
REQ-027 Redirect in WAIT without imem_rvalid: kill flag set; the eventual response SHALL be discarded, then ->REQ at the new pc_q.
REQ-028 Redirect in WAIT with imem_rvalid in the same cycle: that response SHALL be discarded, ->REQ.
REQ-029 A redirect SHALL override stall; a killed response SHALL never reach if_valid.
REQ-030 With stall high and no redirect, if_valid/if_pc/if_instr SHALL hold their values.
REQ-031 Steady state, no stall, single-cycle gnt and next-cycle rvalid: one instruction per 2 cycles.

Reset
REQ-032 While rst_n=0: state IDLE, pc_q=RESET_PC, kill=0, skid empty.
REQ-033 Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), flush=0 when inputs low.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; any rvalid in the first cycle after release SHALL be ignored.

Structure
REQ-035 Shared package fyra_pkg SHALL hold XLEN=32, INSTR_NOP=32'h0000_0013, the fetch_state_t enum (IDLE, REQ, WAIT) and the default RESET_PC.
REQ-036 The one-entry skid buffer (valid, pc, instr) SHALL be a sub-module named fetch_skid; the FSM, pc_q and kill flag SHALL be in fetch_unit.

Verification
REQ-037 Reset release, gnt=1, rvalid one cycle after gnt -> addresses 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 with matching rdata; imem_req low during reset.
REQ-038 branch_sel=1, target=0x0000_0102 while in WAIT -> flush=1 that cycle, in-flight response dropped, next imem_addr=0x0000_0100, if_valid=0 until the 0x100 response arrives.
REQ-039 stall=1 for 4 cycles with two responses returning -> output holds first instruction, skid holds second, FSM in IDLE, no imem_req; stall release -> both delivered in order, then fetch resumes at pc+8.
REQ-040 jump=1 and imem_gnt=1 in the same REQ cycle, target 0x40 -> granted response discarded, next request at 0x40.
REQ-041 RESET_PC=32'hFFFF_FFFC -> second request address 0x0000_0000.
REQ-042 Assert rst_n=0 while in WAIT, then pulse rvalid right after release -> if_valid stays 0, first request at RESET_PC.
